md_unit: RTL

//  Parametrised multi-cycle multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core.

---
 rtl/md_unit_pkg.sv | 48 ++++
 rtl/md_div_step.sv | 35 +++
 rtl/md_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// ============================================================================
//  Module  : md_unit_pkg
//  Purpose : Shared definitions for the multiply/divide unit. Holds the
//            operation codes driven by the E-stage control unit, the FSM
//            state encoding and the accumulate-mode encoding.
//  Ports   : none (package)
//  Config  : MD_MACC_EN enables the MADD/MADDU/MSUB/MSUBU codes in md_unit.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package md_unit_pkg;

   // Operation codes (4-bit, from the E-stage control unit)
   typedef enum logic [3:0] {
      MD_NOP   = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8,
      MD_MADD  = 4'd9,
      MD_MADDU = 4'd10,
      MD_MSUB  = 4'd11,
      MD_MSUBU = 4'd12
   } md_op_e;

   // FSM state encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } md_state_e;

   // How the product is merged into {hi,lo} at commit
   typedef enum logic [1:0] {
      ACC_NONE = 2'd0,
      ACC_ADD  = 2'd1,
      ACC_SUB  = 2'd2
   } md_acc_e;

endpackage

`default_nettype wire

// File: rtl/md_div_step.sv
// ============================================================================
//  Module  : md_div_step
//  Purpose : One combinational radix-2 restoring division step.
//  Ports   : rem_i     [WIDTH:0]   partial remainder from previous step
//            dvd_bit_i             next dividend bit shifted in
//            dvs_i     [WIDTH-1:0] divisor (magnitude)
//            rem_o     [WIDTH:0]   next partial remainder
//            q_o                   quotient bit produced by this step
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module md_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic             dvd_bit_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH:0]   rem_o,
   output logic             q_o
);

   logic [WIDTH+1:0] w_shift;
   logic [WIDTH+1:0] w_diff;

   // One extra guard bit so the borrow of the trial subtraction is visible.
   assign w_shift = {rem_i, dvd_bit_i};
   assign w_diff  = w_shift - {2'b00, dvs_i};
   assign q_o     = ~w_diff[WIDTH+1];
   // Restore (keep the shifted value) when the trial subtraction borrowed.
   assign rem_o   = q_o ? w_diff[WIDTH:0] : w_shift[WIDTH:0];

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
//  Module  : md_unit
//  Purpose : Multi-cycle multiply/divide unit with HI/LO registers for the
//            E stage. Multiply-class ops hold busy for MULT_LAT cycles;
//            divide is an iterative restoring divider (WIDTH+2 busy cycles).
//  Ports   : clk, reset (sync, active-high)
//            start, op[3:0], req   op request / exception suppression
//            rs, rt [WIDTH-1:0]    operands
//            busy                  stall request
//            result [WIDTH-1:0]    HI for MFHI, LO for MFLO, else 0
//            hi, lo [WIDTH-1:0]    architectural HI/LO
//  Config  : `define MD_MACC_EN adds MADD/MADDU/MSUB/MSUBU.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module md_unit
   import md_unit_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic             req,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int             MAXLAT    = (MULT_LAT > WIDTH) ? MULT_LAT : WIDTH;
   localparam int             CW        = $clog2(MAXLAT + 1);
   localparam bit             MUL_MULTI = (MULT_LAT > 1);
   // The accept cycle is the first busy cycle, so MUL runs MULT_LAT-1 cycles.
   localparam logic [CW-1:0]  MUL_LOAD  = CW'((MULT_LAT > 1) ? (MULT_LAT - 2) : 0);
   localparam logic [CW-1:0]  DIV_LOAD  = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

   md_state_e          state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic [2*WIDTH-1:0] prod_q;
   md_acc_e            acc_q;
   logic [WIDTH:0]     rem_q;
   logic [WIDTH-1:0]   quo_q, dvs_q, dvd_q;
   logic               negq_q, negr_q, dz_q;

   logic               dec_mul, dec_div, dec_sgn, dec_mthi, dec_mtlo;
   md_acc_e            dec_acc;
   logic               accept;
   logic [2*WIDTH-1:0] opa_ext, opb_ext, prod_now, hilo_now, hilo_mul;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     rem_nxt;
   logic               qbit;

   function automatic logic [2*WIDTH-1:0] f_mac(input logic [2*WIDTH-1:0] base,
                                                input logic [2*WIDTH-1:0] prod,
                                                input md_acc_e            acc);
      logic [2*WIDTH-1:0] r;
      case (acc)
         ACC_ADD: r = base + prod;
         ACC_SUB: r = base - prod;
         default: r = prod;
      endcase
      return r;
   endfunction

   // ---------------- decode ----------------
   always_comb begin
      dec_mul  = 1'b0;
      dec_div  = 1'b0;
      dec_sgn  = 1'b0;
      dec_mthi = 1'b0;
      dec_mtlo = 1'b0;
      dec_acc  = ACC_NONE;
      case (op)
         MD_MULT:  begin dec_mul = 1'b1; dec_sgn = 1'b1; end
         MD_MULTU: dec_mul = 1'b1;
         MD_DIV:   begin dec_div = 1'b1; dec_sgn = 1'b1; end
         MD_DIVU:  dec_div = 1'b1;
         MD_MTHI:  dec_mthi = 1'b1;
         MD_MTLO:  dec_mtlo = 1'b1;
`ifdef MD_MACC_EN
         MD_MADD:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_acc = ACC_ADD; end
         MD_MADDU: begin dec_mul = 1'b1; dec_acc = ACC_ADD; end
         MD_MSUB:  begin dec_mul = 1'b1; dec_sgn = 1'b1; dec_acc = ACC_SUB; end
         MD_MSUBU: begin dec_mul = 1'b1; dec_acc = ACC_SUB; end
`endif
         default: ;
      endcase
   end

   assign accept = start & ~req & (state_q == ST_IDLE);

   // Extending both operands to 2*WIDTH makes one truncated multiply serve
   // signed and unsigned products alike.
   assign opa_ext  = dec_sgn ? {{WIDTH{rs[WIDTH-1]}}, rs} : {{WIDTH{1'b0}}, rs};
   assign opb_ext  = dec_sgn ? {{WIDTH{rt[WIDTH-1]}}, rt} : {{WIDTH{1'b0}}, rt};
   assign prod_now = opa_ext * opb_ext;
   assign hilo_now = f_mac({hi_q, lo_q}, prod_now, dec_acc);
   assign hilo_mul = f_mac({hi_q, lo_q}, prod_q, acc_q);

   assign abs_a = (dec_sgn & rs[WIDTH-1]) ? -rs : rs;
   assign abs_b = (dec_sgn & rt[WIDTH-1]) ? -rt : rt;

   md_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .dvd_bit_i (quo_q[WIDTH-1]),
      .dvs_i     (dvs_q),
      .rem_o     (rem_nxt),
      .q_o       (qbit)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && dec_mul && MUL_MULTI) state_d = ST_MUL;
            else if (accept && dec_div)        state_d = ST_DIV;
         end
         ST_MUL:  if (cnt_q == '0) state_d = ST_IDLE;
         ST_DIV:  if (cnt_q == '0) state_d = ST_FIX;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy = (state_q != ST_IDLE) | (accept & (dec_mul | dec_div));
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q   <= '0;
         lo_q   <= '0;
         cnt_q  <= '0;
         prod_q <= '0;
         acc_q  <= ACC_NONE;
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         dvd_q  <= '0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
         dz_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (accept) begin
               if (dec_mthi) hi_q <= rs;
               if (dec_mtlo) lo_q <= rs;
               if (dec_mul) begin
                  prod_q <= prod_now;
                  acc_q  <= dec_acc;
                  cnt_q  <= MUL_LOAD;
                  if (!MUL_MULTI) {hi_q, lo_q} <= hilo_now;
               end
               if (dec_div) begin
                  rem_q  <= '0;
                  quo_q  <= abs_a;   // dividend shifts out as quotient shifts in
                  dvs_q  <= abs_b;
                  dvd_q  <= rs;
                  negq_q <= dec_sgn & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                  negr_q <= dec_sgn & rs[WIDTH-1];
                  dz_q   <= (rt == '0);
                  cnt_q  <= DIV_LOAD;
               end
            end
            ST_MUL: begin
               if (cnt_q == '0) {hi_q, lo_q} <= hilo_mul;
               else             cnt_q <= cnt_q - CNT_ONE;
            end
            ST_DIV: begin
               rem_q <= rem_nxt;
               quo_q <= {quo_q[WIDTH-2:0], qbit};
               if (cnt_q != '0) cnt_q <= cnt_q - CNT_ONE;
            end
            default: begin // ST_FIX
               if (dz_q) begin
                  hi_q <= dvd_q;
                  lo_q <= '1;
               end else begin
                  lo_q <= negq_q ? -quo_q : quo_q;
                  hi_q <= negr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
               end
            end
         endcase
      end
   end

   assign hi     = hi_q;
   assign lo     = lo_q;
   assign result = (op == MD_MFHI) ? hi_q :
                   (op == MD_MFLO) ? lo_q : '0;

endmodule

`default_nettype wire
